dma_mem_responder: RTL and testbench
====================================

// Module: dma_mem_responder
// PURPOSE
// - Memory-side endpoint of the DMA address/data protocol. Accepts {addr,len} from the DMA
//   over a valid/enable handshake, then sinks (write) or sources (read) len bytes as 4-bit
//   nibbles, low nibble first, against an internal byte RAM.
// - Replaces the randomised MEM model as the DMA's memory end in system simulation.
// PARAMETERS
// - DEPTH    256  RAM size in bytes; power of two.
// - AW       8    RAM index width = log2(DEPTH); byte index = addr_in[AW-1:0].
// PORTS
// - clk                1 in   1   single clock, rising edge
// - resetn             1 in   1   synchronous, active-low reset
// - mode               in   1   sampled at address accept: 1 = cpu->mem (write RAM), 0 = mem->cpu (read RAM)
// - addr_in_valid      in   1   DMA presents valid addr_in/len_in
// - addr_in_enable     out  1   responder can accept an address (high only in IDLE)
// - addr_in            in   32  start byte address
// - len_in             in   32  transfer length in bytes
// - dma_to_mem_valid   in   1   mem_in_socket carries a valid nibble
// - dma_to_mem_enable  out  1   responder ready to take a nibble (high only in WR)
// - mem_in_socket      in   4   write nibble
// - mem_to_dma_valid   out  1   mem_out_socket carries a valid nibble
// - mem_to_dma_enable  in   1   DMA ready to take a nibble
// - mem_out_socket     out  4   read nibble
// - busy               out  1   high in any state other than IDLE
// - done               out  1   one-cycle pulse in the cycle after the last byte completes
// BEHAVIOUR
// - Transfer rule: a beat transfers on a rising edge where valid & enable are both 1.
// - Reset (resetn==0 at a clock edge): state=IDLE; addr_in_enable=0, dma_to_mem_enable=0,
//   mem_to_dma_valid=0, mem_out_socket=0, busy=0, done=0; byte counter, pointer and nibble
//   phase cleared; any partial byte discarded. RAM contents are not reset. Starting from the
//   first cycle after reset: addr_in_enable=1.
// - States: IDLE, WR, RD_FETCH, RD_SEND. All outputs are registered.
// - IDLE: addr_in_enable=1. On addr accept: ptr<=addr_in[AW-1:0], len<=len_in, cnt<=0,
//   phase<=LO, mode latched.
//   - len_in==0: stay IDLE, pulse done next cycle.
//   - Otherwise go to WR (mode=1) or RD_FETCH (mode=0). addr_in_enable drops at the same edge.
// - WR: dma_to_mem_enable=1.
//   - On a LO beat: lo_reg<=nibble; phase<=HI.
//   - On a HI beat: ram[ptr]<={nibble,lo_reg}; ptr<=ptr+1 (wraps mod DEPTH); cnt<=cnt+1; phase<=LO.
//   - When the HI beat makes cnt==len: go to IDLE. dma_to_mem_enable drops at the same edge;
//     done pulses for one cycle.
// - RD_FETCH: one cycle. rd_byte<=ram[ptr]; mem_out_socket<=ram[ptr][3:0]; mem_to_dma_valid<=1;
//   phase<=LO; go to RD_SEND.
// - RD_SEND: mem_to_dma_valid is held, with data stable, until accepted.
//   - On a LO accept: mem_out_socket<=rd_byte[7:4]; phase<=HI; valid stays 1.
//   - On a HI accept: valid<=0; ptr<=ptr+1 (wraps); cnt<=cnt+1.
//     - If cnt+1==len: go to IDLE and pulse done.
//     - Otherwise go to RD_FETCH (one bubble cycle per byte).
// - dma_to_mem_valid is ignored outside WR. mem_to_dma_enable is ignored outside RD_SEND.
//   addr_in_valid is ignored while busy; no queuing.
// - Counters: cnt and len are 32-bit unsigned compares. ptr is AW bits; wrap from DEPTH-1 to 0
//   is silent.
// - Reset asserted mid-transfer: the rule above applies. Bytes already committed stay in RAM;
//   a half-received byte is never written.
// STRUCTURE
// - dma_pkg holds: state encoding (IDLE/WR/RD_FETCH/RD_SEND), MODE_CPU_TO_MEM=1'b1,
//   MODE_MEM_TO_CPU=1'b0, and the nibble phase constants. The DMA core shares the same package.
// - One sub-module, dma_mem_ram: DEPTH x 8, synchronous write, asynchronous read, no reset.
// - FSM, counters and nibble muxing live in the top level.
// TESTING
// - Write 3 bytes: addr=0x10, len=3, mode=1, nibbles 5,A,3,C,F,0 with valid always 1 ->
//   ram[0x10..0x12]=A5,C3,0F; done pulses once; addr_in_enable returns to 1.
// - Readback: addr=0x10, len=3, mode=0, mem_to_dma_enable=1 -> nibbles 5,A,3,C,F,0 in order;
//   one valid=0 bubble between bytes.
// - Backpressure on read: mem_to_dma_enable toggles randomly -> mem_out_socket is stable while
//   valid & !enable; sequence is unchanged.
// - Wrap: DEPTH=256, write addr=0xFF, len=2, bytes 11,22 -> ram[FF]=11, ram[00]=22.
// - len=0: addr accepted -> no data enables asserted; done pulses one cycle later; state IDLE.
// - Reset after 1.5 bytes of a write: next cycle all outputs are 0 and the first byte is
//   committed. The half byte is absent, and a new address is accepted the cycle after reset
//   releases.

Source files
------------

// File: rtl/dma_pkg.sv
// Constants and payload types shared by the DMA core and its memory-side responder.
package dma_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 32;

  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_WR       = 2'd1;
  localparam logic [STATE_W-1:0] ST_RD_FETCH = 2'd2;
  localparam logic [STATE_W-1:0] ST_RD_SEND  = 2'd3;

  localparam logic MODE_CPU_TO_MEM = 1'b1;
  localparam logic MODE_MEM_TO_CPU = 1'b0;

  localparam logic PH_LO = 1'b0;
  localparam logic PH_HI = 1'b1;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] len;
  } addr_req_t;

  function automatic logic [BYTE_W-1:0] pack_byte(input logic [NIB_W-1:0] hi,
                                                  input logic [NIB_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/dma_mem_ram.sv
// Byte RAM behind the responder: synchronous write, combinational read, contents never reset.
module dma_mem_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dma_mem_responder.sv
// Memory-side endpoint of the DMA protocol: takes {addr,len}, then sinks or sources
// len bytes as nibbles (low nibble first) against an internal byte RAM.
module dma_mem_responder
  import dma_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mode,
  input  logic        addr_in_valid,
  output logic        addr_in_enable,
  input  logic [31:0] addr_in,
  input  logic [31:0] len_in,
  input  logic        dma_to_mem_valid,
  output logic        dma_to_mem_enable,
  input  logic [3:0]  mem_in_socket,
  output logic        mem_to_dma_valid,
  input  logic        mem_to_dma_enable,
  output logic [3:0]  mem_out_socket,
  output logic        busy,
  output logic        done
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [AW-1:0]      ptr_q, ptr_d;
  logic [WORD_W-1:0]  len_q, len_d;
  logic [WORD_W-1:0]  cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic [NIB_W-1:0]   lo_q, lo_d;
  logic [BYTE_W-1:0]  rd_byte_q, rd_byte_d;

  logic               addr_in_enable_d;
  logic               dma_to_mem_enable_d;
  logic               mem_to_dma_valid_d;
  logic [NIB_W-1:0]   mem_out_socket_d;
  logic               busy_d;
  logic               done_d;

  logic               we_c;
  logic [BYTE_W-1:0]  wdata_c;
  logic [BYTE_W-1:0]  rdata_c;
  logic [WORD_W-1:0]  cnt_inc_c;
  addr_req_t          req_c;
  logic               unused_addr_hi;

  assign req_c          = {addr_in, len_in};
  assign unused_addr_hi = ^req_c.addr[WORD_W-1:AW];
  assign cnt_inc_c      = cnt_q + 32'd1;
  assign wdata_c        = pack_byte(mem_in_socket, lo_q);

  // A HI beat landing on a reset edge must not commit its byte.
  dma_mem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we_c & resetn),
    .waddr (ptr_q),
    .wdata (wdata_c),
    .raddr (ptr_q),
    .rdata (rdata_c)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q           <= ST_IDLE;
      ptr_q             <= '0;
      len_q             <= '0;
      cnt_q             <= '0;
      phase_q           <= PH_LO;
      lo_q              <= '0;
      rd_byte_q         <= '0;
      addr_in_enable    <= 1'b0;
      dma_to_mem_enable <= 1'b0;
      mem_to_dma_valid  <= 1'b0;
      mem_out_socket    <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      state_q           <= state_d;
      ptr_q             <= ptr_d;
      len_q             <= len_d;
      cnt_q             <= cnt_d;
      phase_q           <= phase_d;
      lo_q              <= lo_d;
      rd_byte_q         <= rd_byte_d;
      addr_in_enable    <= addr_in_enable_d;
      dma_to_mem_enable <= dma_to_mem_enable_d;
      mem_to_dma_valid  <= mem_to_dma_valid_d;
      mem_out_socket    <= mem_out_socket_d;
      busy              <= busy_d;
      done              <= done_d;
    end
  end

  // Next state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d            = state_q;
    ptr_d              = ptr_q;
    len_d              = len_q;
    cnt_d              = cnt_q;
    phase_d            = phase_q;
    lo_d               = lo_q;
    rd_byte_d          = rd_byte_q;
    mem_to_dma_valid_d = mem_to_dma_valid;
    mem_out_socket_d   = mem_out_socket;
    done_d             = 1'b0;
    we_c               = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (addr_in_valid && addr_in_enable) begin
          ptr_d   = req_c.addr[AW-1:0];
          len_d   = req_c.len;
          cnt_d   = '0;
          phase_d = PH_LO;
          if (req_c.len == '0) begin
            done_d = 1'b1;
          end else if (mode == MODE_CPU_TO_MEM) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD_FETCH;
          end
        end
      end

      ST_WR: begin
        if (dma_to_mem_valid && dma_to_mem_enable) begin
          if (phase_q == PH_LO) begin
            lo_d    = mem_in_socket;
            phase_d = PH_HI;
          end else begin
            we_c    = 1'b1;
            ptr_d   = ptr_q + AW'(1);
            cnt_d   = cnt_inc_c;
            phase_d = PH_LO;
            if (cnt_inc_c == len_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end

      ST_RD_FETCH: begin
        rd_byte_d          = rdata_c;
        mem_out_socket_d   = rdata_c[NIB_W-1:0];
        mem_to_dma_valid_d = 1'b1;
        phase_d            = PH_LO;
        state_d            = ST_RD_SEND;
      end

      ST_RD_SEND: begin
        if (mem_to_dma_valid && mem_to_dma_enable) begin
          if (phase_q == PH_LO) begin
            mem_out_socket_d = rd_byte_q[BYTE_W-1:NIB_W];
            phase_d          = PH_HI;
          end else begin
            mem_to_dma_valid_d = 1'b0;
            ptr_d              = ptr_q + AW'(1);
            cnt_d              = cnt_inc_c;
            if (cnt_inc_c == len_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RD_FETCH;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    addr_in_enable_d    = (state_d == ST_IDLE);
    dma_to_mem_enable_d = (state_d == ST_WR);
    busy_d              = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_dma_mem_responder.sv
// Randomised bench for dma_mem_responder against a byte-array model of the RAM.
module tb_dma_mem_responder;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mode = 1'b0;
  logic        addr_in_valid = 1'b0;
  logic        addr_in_enable;
  logic [31:0] addr_in = '0;
  logic [31:0] len_in = '0;
  logic        dma_to_mem_valid = 1'b0;
  logic        dma_to_mem_enable;
  logic [3:0]  mem_in_socket = '0;
  logic        mem_to_dma_valid;
  logic        mem_to_dma_enable = 1'b0;
  logic [3:0]  mem_out_socket;
  logic        busy;
  logic        done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  ref_mem [256];

  always #5 clk = ~clk;

  dma_mem_responder #(.DEPTH(256), .AW(8)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .mode              (mode),
    .addr_in_valid     (addr_in_valid),
    .addr_in_enable    (addr_in_enable),
    .addr_in           (addr_in),
    .len_in            (len_in),
    .dma_to_mem_valid  (dma_to_mem_valid),
    .dma_to_mem_enable (dma_to_mem_enable),
    .mem_in_socket     (mem_in_socket),
    .mem_to_dma_valid  (mem_to_dma_valid),
    .mem_to_dma_enable (mem_to_dma_enable),
    .mem_out_socket    (mem_out_socket),
    .busy              (busy),
    .done              (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_addr_en"}, addr_in_enable, 0);
    check_eq({tag, "_wr_en"}, dma_to_mem_enable, 0);
    check_eq({tag, "_rd_valid"}, mem_to_dma_valid, 0);
    check_eq({tag, "_socket"}, mem_out_socket, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_addr(input logic [7:0] a, input logic [31:0] l, input logic m);
    int unsigned w = 0;
    logic [31:0] hi;
    while (!addr_in_enable && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("addr_ready", addr_in_enable, 1);
    hi = $urandom;
    addr_in = {hi[31:8], a};
    len_in = l;
    mode = m;
    addr_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    addr_in_valid = 1'b0;
    addr_in = $urandom;
    len_in = $urandom;
  endtask

  task automatic do_write(input logic [7:0] a, input int unsigned n, input byte_q_t data,
                          input bit gaps);
    logic [3:0] nib[$];
    int unsigned idx = 0;
    int unsigned cyc = 0;
    int unsigned early_done = 0;
    bit v, en;
    for (int i = 0; i < int'(n); i++) begin
      nib.push_back(data[i][3:0]);
      nib.push_back(data[i][7:4]);
    end
    send_addr(a, n, 1'b1);
    while (idx < nib.size() && cyc < 8 * n + 100) begin
      en = dma_to_mem_enable;
      check_eq("wr_enable", en, 1);
      if (cyc == 0) check_eq("wr_addr_en_low", addr_in_enable, 0);
      if (done) early_done++;
      v = !gaps || ($urandom_range(0, 2) != 0);
      dma_to_mem_valid = v;
      mem_in_socket = v ? nib[idx] : 4'($urandom);
      @(posedge clk);
      if (v && en) idx++;
      @(negedge clk);
      cyc++;
    end
    dma_to_mem_valid = 1'b0;
    check_eq("wr_nibbles", idx, nib.size());
    check_eq("wr_early_done", early_done, 0);
    check_eq("wr_done", done, 1);
    check_eq("wr_end_busy", busy, 0);
    check_eq("wr_end_wr_en", dma_to_mem_enable, 0);
    check_eq("wr_end_addr_en", addr_in_enable, 1);
    for (int i = 0; i < int'(n); i++) ref_mem[8'(a + 8'(i))] = data[i];
    @(negedge clk);
    check_eq("wr_done_pulse", done, 0);
  endtask

  task automatic do_read(input logic [7:0] a, input int unsigned n, input bit bp);
    logic [3:0] exp[$];
    logic [7:0] b;
    logic [3:0] d;
    logic [3:0] pd = '0;
    int unsigned idx = 0;
    int unsigned cyc = 0;
    int unsigned early_done = 0;
    bit v, en, gap;
    bit pv = 1'b0;
    bit pen = 1'b0;
    gap = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      b = ref_mem[8'(a + 8'(i))];
      exp.push_back(b[3:0]);
      exp.push_back(b[7:4]);
    end
    send_addr(a, n, 1'b0);
    while (idx < exp.size() && cyc < 16 * n + 100) begin
      v = mem_to_dma_valid;
      d = mem_out_socket;
      if (done) early_done++;
      if (gap) check_eq("rd_bubble", v, 0);
      gap = 1'b0;
      if (pv && !pen && v) check_eq("rd_hold", d, pd);
      en = !bp || ($urandom_range(0, 1) == 1);
      mem_to_dma_enable = en;
      if (v && en) begin
        check_eq($sformatf("rd_nib%0d", idx), d, exp[idx]);
        idx++;
        if (idx % 2 == 0) gap = 1'b1;
      end
      pv = v;
      pen = en;
      pd = d;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    mem_to_dma_enable = 1'b0;
    check_eq("rd_nibbles", idx, exp.size());
    check_eq("rd_early_done", early_done, 0);
    check_eq("rd_done", done, 1);
    check_eq("rd_end_valid", mem_to_dma_valid, 0);
    check_eq("rd_end_busy", busy, 0);
    check_eq("rd_end_addr_en", addr_in_enable, 1);
    @(negedge clk);
    check_eq("rd_done_pulse", done, 0);
  endtask

  task automatic do_len0(input logic m);
    send_addr(8'($urandom), 0, m);
    check_eq("len0_done", done, 1);
    check_eq("len0_busy", busy, 0);
    check_eq("len0_wr_en", dma_to_mem_enable, 0);
    check_eq("len0_rd_valid", mem_to_dma_valid, 0);
    check_eq("len0_addr_en", addr_in_enable, 1);
    @(negedge clk);
    check_eq("len0_done_pulse", done, 0);
    check_eq("len0_wr_en2", dma_to_mem_enable, 0);
    check_eq("len0_rd_valid2", mem_to_dma_valid, 0);
  endtask

  initial begin
    byte_q_t wq;
    logic [7:0] b0, b1;
    logic [7:0] ra;
    int unsigned rl;

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    @(negedge clk);
    check_eq("post_reset_addr_en", addr_in_enable, 1);
    check_eq("post_reset_busy", busy, 0);

    // Fill the whole RAM so the model starts fully defined.
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back(8'($urandom));
    do_write(8'h00, 256, wq, 1'b0);

    wq.delete();
    wq.push_back(8'hA5);
    wq.push_back(8'hC3);
    wq.push_back(8'h0F);
    do_write(8'h10, 3, wq, 1'b0);
    do_read(8'h10, 3, 1'b0);
    do_read(8'h10, 3, 1'b1);

    wq.delete();
    wq.push_back(8'h11);
    wq.push_back(8'h22);
    do_write(8'hFF, 2, wq, 1'b1);
    do_read(8'hFF, 2, 1'b1);
    do_read(8'h00, 1, 1'b0);

    do_len0(1'b1);
    do_len0(1'b0);

    repeat (30) begin
      ra = 8'($urandom);
      rl = $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int i = 0; i < int'(rl); i++) wq.push_back(8'($urandom));
        do_write(ra, rl, wq, ($urandom_range(0, 1) == 1));
      end else begin
        do_read(ra, rl, ($urandom_range(0, 1) == 1));
      end
    end

    // Reset after one and a half bytes of a write.
    b0 = 8'($urandom);
    b1 = ~ref_mem[8'h41];
    send_addr(8'h40, 4, 1'b1);
    dma_to_mem_valid = 1'b1;
    mem_in_socket = b0[3:0];
    @(posedge clk); @(negedge clk);
    mem_in_socket = b0[7:4];
    @(posedge clk); @(negedge clk);
    mem_in_socket = b1[3:0];
    @(posedge clk); @(negedge clk);
    resetn = 1'b0;
    dma_to_mem_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check_all_zero("mid_reset");
    ref_mem[8'h40] = b0;
    resetn = 1'b1;
    @(negedge clk);
    check_eq("mid_reset_addr_en", addr_in_enable, 1);
    do_read(8'h40, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
